// File: rtl/unum4_add_arbiter.sv
// unum4_add_arbiter
// Round-robin front end that shares one pipelined unum4 adder/subtractor
// (fixed start-to-done latency LAT) among NREQ requesters. At most one
// operation is granted per cycle. The granted operands are registered onto
// the adder inputs. The requester id travels alongside in a tag pipe so that
// each result comes back as a one-hot response pulse to its owner.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   en                issue enable (no new grants while low; in-flight ops drain)
//   req_valid/ready   per-requester handshake (ready is one-hot, combinational)
//   req_op/m_*/e_*    per-requester operation and flattened operands
//   add_*             adder start/op/operands out; done/result/flags in
//   resp_*            one-hot response pulse plus result pass-through
//   inflight, idle    occupancy status
module unum4_add_arbiter #(
  parameter int NREQ      = 4,
  parameter int ID_W      = 2,
  parameter int MAN_MAX_W = 29,
  parameter int EXP_MAX_W = 16,
  parameter int EXTRA     = 0,
  parameter int LAT       = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_op,
  input  logic [NREQ*MAN_MAX_W-1:0]    req_m_a,
  input  logic [NREQ*MAN_MAX_W-1:0]    req_m_b,
  input  logic [NREQ*EXP_MAX_W-1:0]    req_e_a,
  input  logic [NREQ*EXP_MAX_W-1:0]    req_e_b,
  output logic                         add_start,
  output logic                         add_op,
  output logic [MAN_MAX_W-1:0]         add_m_a,
  output logic [MAN_MAX_W-1:0]         add_m_b,
  output logic [EXP_MAX_W-1:0]         add_e_a,
  output logic [EXP_MAX_W-1:0]         add_e_b,
  input  logic                         add_done,
  input  logic [MAN_MAX_W+EXTRA-1:0]   add_m_o,
  input  logic [EXP_MAX_W-1:0]         add_e_o,
  input  logic                         add_over,
  input  logic                         add_under,
  output logic [NREQ-1:0]              resp_valid,
  output logic                         resp_nores,
  output logic [MAN_MAX_W+EXTRA-1:0]   resp_m,
  output logic [EXP_MAX_W-1:0]         resp_e,
  output logic                         resp_over,
  output logic                         resp_under,
  output logic [$clog2(LAT+2)-1:0]     inflight,
  output logic                         idle
);

  localparam int CNT_W = $clog2(LAT + 2);

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 gnt_any;
  logic [ID_W-1:0]      gnt_id;

  logic                 start_q;
  logic [ID_W-1:0]      iss_id_q;
  logic                 op_q;
  logic [MAN_MAX_W-1:0] ma_q, mb_q;
  logic [EXP_MAX_W-1:0] ea_q, eb_q;

  logic [LAT-1:0]       tag_v_q;
  logic [ID_W-1:0]      tag_id_q [LAT];

  logic [CNT_W-1:0]     inflight_q, inflight_d;

  // Round-robin search starting at the pointer; the first valid requester wins.
  // The pointer then moves just past the winner so it gets lowest priority next.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (en && !gnt_any && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'((int'(ptr_q) + k) % NREQ);
      end
    end
    req_ready = '0;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
  end

  // The issued id is kept next to the operands so the tag pipe can start from
  // the cycle in which add_start is high. The tail entry is then valid exactly
  // in the cycle the adder presents that operation's result.
  always_comb begin
    inflight_d = inflight_q + CNT_W'(start_q) - CNT_W'(tag_v_q[LAT-1]);
  end

  // Issue register, tag pipe and occupancy counter. Reset discards every
  // in-flight tag, so no response is ever produced for those operations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      start_q    <= 1'b0;
      iss_id_q   <= '0;
      op_q       <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      ea_q       <= '0;
      eb_q       <= '0;
      tag_v_q    <= '0;
      for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      start_q <= gnt_any;
      if (gnt_any) begin
        iss_id_q <= gnt_id;
        op_q     <= req_op[gnt_id];
        ma_q     <= req_m_a[gnt_id*MAN_MAX_W +: MAN_MAX_W];
        mb_q     <= req_m_b[gnt_id*MAN_MAX_W +: MAN_MAX_W];
        ea_q     <= req_e_a[gnt_id*EXP_MAX_W +: EXP_MAX_W];
        eb_q     <= req_e_b[gnt_id*EXP_MAX_W +: EXP_MAX_W];
      end
      tag_v_q[0]  <= start_q;
      tag_id_q[0] <= iss_id_q;
      for (int i = 1; i < LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      inflight_q <= inflight_d;
    end
  end

  // Responses follow the tail tag only. add_done with an empty tail is ignored.
  // A missing done on a valid tail still produces the pulse, flagged as nores.
  always_comb begin
    resp_valid = '0;
    if (tag_v_q[LAT-1]) resp_valid[tag_id_q[LAT-1]] = 1'b1;
    resp_nores = tag_v_q[LAT-1] & ~add_done;
    resp_m     = add_m_o;
    resp_e     = add_e_o;
    resp_over  = add_over;
    resp_under = add_under;
  end

  assign add_start = start_q;
  assign add_op    = op_q;
  assign add_m_a   = ma_q;
  assign add_m_b   = mb_q;
  assign add_e_a   = ea_q;
  assign add_e_b   = eb_q;
  assign inflight  = inflight_q;
  assign idle      = (inflight_q == '0) && !(|req_valid);

endmodule

// File: tb/tb_unum4_add_arbiter.sv
// Testbench for unum4_add_arbiter. A behavioural adder model with latency
// LAT sits on the adder side. Expected grants, issue data, responses and
// occupancy come from a per-operation record queue indexed by cycle number.
module tb_unum4_add_arbiter;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int MW    = 29;
  localparam int EW    = 16;
  localparam int EXTRA = 0;
  localparam int LAT   = 6;
  localparam int RW    = MW + EXTRA;
  localparam int CW    = $clog2(LAT + 2);

  logic clk = 1'b0;
  logic rst, en;
  logic [NREQ-1:0]    req_valid, req_ready, req_op;
  logic [NREQ*MW-1:0] req_m_a, req_m_b;
  logic [NREQ*EW-1:0] req_e_a, req_e_b;
  logic               add_start, add_op, add_done, add_over, add_under;
  logic [MW-1:0]      add_m_a, add_m_b;
  logic [EW-1:0]      add_e_a, add_e_b, add_e_o;
  logic [RW-1:0]      add_m_o;
  logic [NREQ-1:0]    resp_valid;
  logic               resp_nores, resp_over, resp_under, idle;
  logic [RW-1:0]      resp_m;
  logic [EW-1:0]      resp_e;
  logic [CW-1:0]      inflight;

  logic [MW-1:0] opA [NREQ];
  logic [MW-1:0] opB [NREQ];
  logic [EW-1:0] exA [NREQ];
  logic [EW-1:0] exB [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : gFlat
    assign req_m_a[g*MW +: MW] = opA[g];
    assign req_m_b[g*MW +: MW] = opB[g];
    assign req_e_a[g*EW +: EW] = exA[g];
    assign req_e_b[g*EW +: EW] = exB[g];
  end

  unum4_add_arbiter #(
    .NREQ(NREQ), .ID_W(ID_W), .MAN_MAX_W(MW), .EXP_MAX_W(EW), .EXTRA(EXTRA), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_m_a(req_m_a), .req_m_b(req_m_b), .req_e_a(req_e_a), .req_e_b(req_e_b),
    .add_start(add_start), .add_op(add_op),
    .add_m_a(add_m_a), .add_m_b(add_m_b), .add_e_a(add_e_a), .add_e_b(add_e_b),
    .add_done(add_done), .add_m_o(add_m_o), .add_e_o(add_e_o),
    .add_over(add_over), .add_under(add_under),
    .resp_valid(resp_valid), .resp_nores(resp_nores), .resp_m(resp_m), .resp_e(resp_e),
    .resp_over(resp_over), .resp_under(resp_under),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // Behavioural adder result functions shared by the adder model and the checker
  function automatic logic [RW-1:0] mockMant(input logic op, input logic [MW-1:0] a, input logic [MW-1:0] b);
    return RW'(op ? (a - b) : (a + b));
  endfunction
  function automatic logic [EW-1:0] mockExp(input logic [EW-1:0] a, input logic [EW-1:0] b);
    return EW'(a + b);
  endfunction
  function automatic logic mockOver(input logic [MW-1:0] a, input logic [MW-1:0] b);
    return a[MW-1] & b[MW-1];
  endfunction
  function automatic logic mockUnder(input logic op, input logic [MW-1:0] a, input logic [MW-1:0] b);
    return op & (a < b);
  endfunction

  // Adder model: start seen in cycle S yields done in cycle S+LAT. It is not
  // cleared by the DUT reset, so stale dones after a reset must be ignored.
  logic          mockRun, killDone;
  logic          mv [LAT];
  logic [RW-1:0] mm [LAT];
  logic [EW-1:0] me [LAT];
  logic          mo [LAT];
  logic          mu [LAT];

  always @(posedge clk) begin
    if (!mockRun) begin
      for (int i = 0; i < LAT; i++) mv[i] <= 1'b0;
    end else begin
      mv[0] <= add_start;
      mm[0] <= mockMant(add_op, add_m_a, add_m_b);
      me[0] <= mockExp(add_e_a, add_e_b);
      mo[0] <= mockOver(add_m_a, add_m_b);
      mu[0] <= mockUnder(add_op, add_m_a, add_m_b);
      for (int i = 1; i < LAT; i++) begin
        mv[i] <= mv[i-1];
        mm[i] <= mm[i-1];
        me[i] <= me[i-1];
        mo[i] <= mo[i-1];
        mu[i] <= mu[i-1];
      end
    end
  end

  assign add_done  = mv[LAT-1] & ~killDone;
  assign add_m_o   = mm[LAT-1];
  assign add_e_o   = me[LAT-1];
  assign add_over  = mo[LAT-1];
  assign add_under = mu[LAT-1];

  typedef struct {
    int            g;
    int            id;
    logic          op;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
  } rec_t;

  rec_t recQ[$];
  int   ptr, cyc, killAt, lastGrantCyc;
  int   total, bad;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock cycle with the inputs currently driven: check, update model, advance.
  task automatic applyStimulus();
    int            g, cnt;
    logic          hasStart, hasResp;
    rec_t          rs, rr;
    logic [NREQ-1:0] expReady, expResp;
    rec_t          keep[$];
    killDone = (cyc == killAt);
    #1;
    g = -1;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("req_ready", req_ready, expReady);

    hasStart = 1'b0;
    hasResp  = 1'b0;
    cnt      = 0;
    foreach (recQ[i]) begin
      if (recQ[i].g == cyc - 1) begin hasStart = 1'b1; rs = recQ[i]; end
      if (recQ[i].g + 1 + LAT == cyc) begin hasResp = 1'b1; rr = recQ[i]; end
      if (recQ[i].g + 1 < cyc && cyc <= recQ[i].g + 1 + LAT) cnt++;
    end

    checkOutput("add_start", add_start, hasStart);
    if (hasStart) begin
      checkOutput("add_op", add_op, rs.op);
      checkOutput("add_m_a", add_m_a, rs.a);
      checkOutput("add_m_b", add_m_b, rs.b);
      checkOutput("add_e_a", add_e_a, rs.ea);
      checkOutput("add_e_b", add_e_b, rs.eb);
    end

    expResp = '0;
    if (hasResp) expResp[rr.id] = 1'b1;
    checkOutput("resp_valid", resp_valid, expResp);
    if (hasResp) begin
      checkOutput("resp_nores", resp_nores, killDone);
      if (!killDone) begin
        checkOutput("resp_m", resp_m, mockMant(rr.op, rr.a, rr.b));
        checkOutput("resp_e", resp_e, mockExp(rr.ea, rr.eb));
        checkOutput("resp_over", resp_over, mockOver(rr.a, rr.b));
        checkOutput("resp_under", resp_under, mockUnder(rr.op, rr.a, rr.b));
      end
    end

    checkOutput("inflight", inflight, cnt);
    checkOutput("idle", idle, (cnt == 0) && (req_valid == '0));

    if (g >= 0) begin
      recQ.push_back('{g: cyc, id: g, op: req_op[g], a: opA[g], b: opB[g], ea: exA[g], eb: exB[g]});
      ptr          = (g + 1) % NREQ;
      lastGrantCyc = cyc;
    end
    foreach (recQ[i]) if (recQ[i].g + 1 + LAT >= cyc) keep.push_back(recQ[i]);
    recQ = keep;

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic randOperands();
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = MW'($urandom);
      opB[i] = MW'($urandom);
      exA[i] = EW'($urandom);
      exB[i] = EW'($urandom);
    end
    req_op = NREQ'($urandom);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; ptr = 0; killAt = -1; lastGrantCyc = -1;
    rst = 1'b1; en = 1'b0; req_valid = '0; req_op = '0;
    killDone = 1'b0; mockRun = 1'b0;
    for (int i = 0; i < NREQ; i++) begin opA[i] = '0; opB[i] = '0; exA[i] = '0; exB[i] = '0; end

    // Asynchronous reset entry and reset state
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_add_start", add_start, 1'b0);
    checkOutput("rst_resp_valid", resp_valid, '0);
    checkOutput("rst_inflight", inflight, '0);
    checkOutput("rst_idle", idle, 1'b1);
    checkOutput("rst_add_m_a", add_m_a, '0);
    @(negedge clk);
    mockRun = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus();

    // Single add from requester 2: 1.5 + 1.5 at exponent 0
    opA[2] = 29'h0C00_0000; opB[2] = 29'h0C00_0000; exA[2] = '0; exB[2] = '0;
    req_op = '0; req_valid = 4'b0100;
    applyStimulus();
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) applyStimulus();

    // All requesters held high for 8 cycles, then drain
    randOperands();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) applyStimulus();
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) applyStimulus();

    // Issue disabled with everything requesting, then resume at the held pointer
    req_valid = 4'b1011;
    applyStimulus();
    en = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) applyStimulus();
    en = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus();
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) applyStimulus();

    // Subtract with underflow whose done is suppressed at its response slot
    opA[1] = 29'h0000_0010; opB[1] = 29'h0100_0000; req_op = 4'b0010;
    req_valid = 4'b0010;
    applyStimulus();
    killAt = lastGrantCyc + 1 + LAT;
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) applyStimulus();
    killAt = -1;

    // Reset with three operations in flight; pointer restarts at requester 0
    randOperands();
    req_valid = 4'b1110;
    for (int i = 0; i < 3; i++) applyStimulus();
    req_valid = '0;
    applyStimulus();
    checkOutput("pre_rst_inflight", inflight, 3);
    req_valid = 4'b1010;
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_add_start", add_start, 1'b0);
    checkOutput("arst_resp_valid", resp_valid, '0);
    checkOutput("arst_inflight", inflight, '0);
    checkOutput("arst_add_op", add_op, 1'b0);
    recQ.delete();
    ptr = 0;
    @(posedge clk); @(negedge clk); cyc++;
    @(posedge clk); @(negedge clk); cyc++;
    rst = 1'b1;
    applyStimulus();
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) applyStimulus();

    // One grant every other cycle: issue and retire coincide at inflight = 3
    for (int i = 0; i < 20; i++) begin
      randOperands();
      req_valid = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      applyStimulus();
    end
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) applyStimulus();

    // Randomized traffic with occasional issue disable
    for (int i = 0; i < 80; i++) begin
      randOperands();
      req_valid = NREQ'($urandom);
      en = ($urandom_range(0, 7) != 0);
      applyStimulus();
    end
    en = 1'b1; req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
